// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: one-hot instruction bit indices,
// the fetch-stage state encoding and the default reset PC.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // Bit positions in the one-hot decoded instruction vector.
  localparam int INS_ADDU  = 0;
  localparam int INS_SUBU  = 1;
  localparam int INS_ADD   = 2;
  localparam int INS_SUB   = 3;
  localparam int INS_AND   = 4;
  localparam int INS_OR    = 5;
  localparam int INS_XOR   = 6;
  localparam int INS_NOR   = 7;
  localparam int INS_SLT   = 8;
  localparam int INS_SLTU  = 9;
  localparam int INS_SLL   = 10;
  localparam int INS_SRL   = 11;
  localparam int INS_SRA   = 12;
  localparam int INS_SLLV  = 13;
  localparam int INS_SRLV  = 14;
  localparam int INS_SRAV  = 15;
  localparam int INS_JR    = 16;
  localparam int INS_ADDI  = 17;
  localparam int INS_ADDIU = 18;
  localparam int INS_ANDI  = 19;
  localparam int INS_ORI   = 20;
  localparam int INS_XORI  = 21;
  localparam int INS_LW    = 22;
  localparam int INS_SW    = 23;
  localparam int INS_BEQ   = 24;
  localparam int INS_BNE   = 25;
  localparam int INS_SLTI  = 26;
  localparam int INS_SLTIU = 27;
  localparam int INS_LUI   = 28;
  localparam int INS_J     = 29;
  localparam int INS_JAL   = 30;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HOLD,
    ST_RESOLVE
  } fetch_state_e;

  // Sign-extended, word-scaled branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_next_pc.sv
// Next-PC resolution for the fetch stage: picks the jump, branch, register
// or sequential target from the one-hot decoded instruction vector.
module cpu_next_pc (
  input  logic [31:0] br_ins,
  input  logic [31:0] br_rs,
  input  logic [31:0] br_rt,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc4,
  output logic [31:0] next_pc,
  output logic        illegal
);
  import cpu_pkg::*;

  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        ops_equal;
  logic        unused_opcode;

  // The opcode field is already captured by the decoded vector.
  assign unused_opcode = ^if_instr[31:26];

  assign jump_target   = {if_pc4[31:28], if_instr[25:0], 2'b00};
  assign branch_target = if_pc4 + branch_offset(if_instr[15:0]);
  assign ops_equal     = (br_rs == br_rt);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    next_pc = if_pc4;
    illegal = (br_ins == 32'd0);
    // A multi-hot vector is a decoder defect; the if-chain fixes the priority.
    if (br_ins[INS_JAL] || br_ins[INS_J]) begin
      next_pc = jump_target;
    end else if (br_ins[INS_BNE]) begin
      if (!ops_equal) next_pc = branch_target;
    end else if (br_ins[INS_BEQ]) begin
      if (ops_equal) next_pc = branch_target;
    end else if (br_ins[INS_JR]) begin
      next_pc = br_rs;
    end
  end

endmodule

// File: rtl/cpu_pc_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over a
// req/rvalid handshake, hands it to decode and waits for its resolution.
module cpu_pc_fetch #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        id_ready,
  input  logic        br_valid,
  input  logic [31:0] br_ins,
  input  logic [31:0] br_rs,
  input  logic [31:0] br_rt,
  output logic        illegal
);
  import cpu_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;
  logic [31:0]  next_pc;
  logic         ins_illegal;
  logic         resolve_fire;

  cpu_next_pc u_next_pc (
    .br_ins   (br_ins),
    .br_rs    (br_rs),
    .br_rt    (br_rt),
    .if_instr (if_instr_q),
    .if_pc4   (if_pc4),
    .next_pc  (next_pc),
    .illegal  (ins_illegal)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    imem_req     = 1'b0;
    if_valid     = 1'b0;
    resolve_fire = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_rvalid) begin
          if_instr_d = imem_rdata;
          if_pc_d    = pc_q;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if_valid = 1'b1;
        if (id_ready) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (br_valid) begin
          resolve_fire = 1'b1;
          pc_d         = next_pc;
          state_d      = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      if_instr_q <= 32'd0;
      if_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_pc4    = if_pc_q + 32'd4;
  assign illegal   = resolve_fire & ins_illegal;

endmodule

// File: tb/tb_cpu_pc_fetch.sv
// Self-checking bench for cpu_pc_fetch: directed test-plan scenarios plus
// randomized instruction traffic compared against a transaction-level model.
module tb_cpu_pc_fetch;
  import cpu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        id_ready;
  logic        br_valid;
  logic [31:0] br_ins;
  logic [31:0] br_rs;
  logic [31:0] br_rt;
  logic        illegal;

  always #5 clk = ~clk;

  cpu_pc_fetch #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .id_ready    (id_ready),
    .br_valid    (br_valid),
    .br_ins      (br_ins),
    .br_rs       (br_rs),
    .br_rt       (br_rt),
    .illegal     (illegal)
  );

  // Phase of the current instruction as implied by the stimulus and the timing rules.
  typedef enum int {PH_IDLE, PH_FETCH, PH_HOLD, PH_RESOLVE} phase_e;

  phase_e      phase;
  logic        chk_en = 1'b0;
  logic [31:0] exp_pc;
  logic [31:0] exp_if_instr;
  logic [31:0] exp_if_pc;
  logic        exp_illegal;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC rule: highest-priority set bit decides.
  function automatic logic [31:0] model_next(input logic [31:0] vec, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [31:0] instr,
                                             input logic [31:0] pc);
    logic [31:0] pc4;
    logic [31:0] off;
    logic [31:0] tgt;
    pc4 = pc + 32'd4;
    off = 32'($signed(instr[15:0]));
    tgt = pc4 + (off << 2);
    if (vec[30] || vec[29]) return (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if (vec[25]) return (rs != rt) ? tgt : pc4;
    if (vec[24]) return (rs == rt) ? tgt : pc4;
    if (vec[16]) return rs;
    return pc4;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_req", 32'(imem_req), 32'(phase == PH_FETCH));
      if (phase == PH_FETCH) check("imem_addr", imem_addr, exp_pc);
      check("if_valid", 32'(if_valid), 32'(phase == PH_HOLD));
      check("if_instr", if_instr, exp_if_instr);
      check("if_pc", if_pc, exp_if_pc);
      check("if_pc4", if_pc4, exp_if_pc + 32'd4);
      check("illegal", 32'(illegal), 32'(exp_illegal));
    end
  end

  // Randomize every input; callers then force the one that matters in the phase.
  task automatic noise();
    imem_rvalid = 1'($urandom);
    imem_rdata  = $urandom;
    id_ready    = 1'($urandom);
    br_valid    = 1'($urandom);
    br_ins      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    br_rs       = $urandom;
    br_rt       = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_model();
    phase        = PH_IDLE;
    exp_pc       = RST_PC;
    exp_if_instr = 32'd0;
    exp_if_pc    = RST_PC;
    exp_illegal  = 1'b0;
  endtask

  // Runs one instruction starting in a FETCH cycle; ends in the following FETCH cycle.
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] vec,
                           input logic [31:0] rs, input logic [31:0] rt,
                           input int waits, input int stalls, input int dly,
                           input logic lit_en, input logic [31:0] lit_pc4,
                           input logic [31:0] lit_next);
    logic [31:0] nxt;
    for (int i = 0; i < waits; i++) begin
      noise();
      imem_rvalid = 1'b0;
      step();
    end
    noise();
    imem_rvalid = 1'b1;
    imem_rdata  = instr;
    step();
    phase        = PH_HOLD;
    exp_if_instr = instr;
    exp_if_pc    = exp_pc;
    if (lit_en) check("lit_if_pc4", if_pc4, lit_pc4);
    for (int i = 0; i < stalls; i++) begin
      noise();
      id_ready = 1'b0;
      step();
    end
    noise();
    id_ready = 1'b1;
    step();
    phase = PH_RESOLVE;
    for (int i = 0; i < dly; i++) begin
      noise();
      br_valid = 1'b0;
      step();
    end
    noise();
    br_valid    = 1'b1;
    br_ins      = vec;
    br_rs       = rs;
    br_rt       = rt;
    exp_illegal = (vec == 32'd0);
    nxt = model_next(vec, rs, rt, exp_if_instr, exp_if_pc);
    step();
    br_valid    = 1'b0;
    exp_illegal = 1'b0;
    phase       = PH_FETCH;
    exp_pc      = nxt;
    if (lit_en) check("lit_next_pc", imem_addr, lit_next);
  endtask

  // Reset while FETCH waits, with a stale response arriving just after release.
  task automatic reset_mid_fetch();
    noise();
    imem_rvalid = 1'b0;
    step();
    noise();
    imem_rvalid = 1'b0;
    rst = 1'b1;
    step();
    set_reset_model();
    rst = 1'b0;
    noise();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    phase = PH_FETCH;
    check("lit_rst_addr", imem_addr, RST_PC);
    check("lit_rst_valid", 32'(if_valid), 32'd0);
  endtask

  logic [31:0] v_addi, v_beq, v_bne, v_j, v_jal, v_jr;

  initial begin
    logic [31:0] vec, rs, rt;
    v_addi = 32'd1 << INS_ADDI;
    v_beq  = 32'd1 << INS_BEQ;
    v_bne  = 32'd1 << INS_BNE;
    v_j    = 32'd1 << INS_J;
    v_jal  = 32'd1 << INS_JAL;
    v_jr   = 32'd1 << INS_JR;

    // Hand-computed values that pin the reference model.
    check("model_beq_taken", model_next(v_beq, 32'd7, 32'd7, 32'h1109_FFFC, 32'h0040_0010), 32'h0040_0004);
    check("model_beq_not", model_next(v_beq, 32'd7, 32'd8, 32'h1109_FFFC, 32'h0040_0010), 32'h0040_0014);
    check("model_j", model_next(v_j, 32'd0, 32'd0, 32'h0810_0008, 32'h0040_0020), 32'h0040_0020);
    check("model_wrap", model_next(32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC), 32'h0000_0000);
    check("model_prio", model_next(v_jal | v_jr, 32'h1234_5678, 32'd0, 32'h0000_0001, 32'h8000_0000), 32'h8000_0004);

    rst = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'd0; id_ready = 1'b0;
    br_valid = 1'b0; br_ins = 32'd0; br_rs = 32'd0; br_rt = 32'd0;
    set_reset_model();
    repeat (3) step();
    chk_en = 1'b1;
    rst = 1'b0;
    noise();
    step();
    phase = PH_FETCH;
    check("lit_first_addr", imem_addr, 32'h0040_0000);

    run_instr(32'h2008_0005, v_addi, 32'd0, 32'd0, 0, 0, 1, 1'b1, 32'h0040_0004, 32'h0040_0004);
    run_instr(32'h2009_0001, v_addi, 32'd0, 32'd0, 2, 3, 1, 1'b1, 32'h0040_0008, 32'h0040_0008);
    run_instr(32'h0200_0008, v_jr, 32'h0040_0010, 32'd0, 0, 0, 1, 1'b1, 32'h0040_000C, 32'h0040_0010);
    run_instr(32'h1109_FFFC, v_beq, 32'd7, 32'd7, 1, 0, 1, 1'b1, 32'h0040_0014, 32'h0040_0004);
    run_instr(32'h0200_0008, v_jr, 32'h0040_0010, 32'd0, 0, 1, 0, 1'b1, 32'h0040_0008, 32'h0040_0010);
    run_instr(32'h1109_FFFC, v_beq, 32'd7, 32'd9, 0, 0, 2, 1'b1, 32'h0040_0014, 32'h0040_0014);
    run_instr(32'h0200_0008, v_jr, 32'h0040_0020, 32'd0, 0, 0, 1, 1'b1, 32'h0040_0018, 32'h0040_0020);
    run_instr(32'h0810_0008, v_j, 32'd0, 32'd0, 0, 0, 1, 1'b1, 32'h0040_0024, 32'h0040_0020);
    run_instr(32'h0200_0008, v_jr, 32'h0040_0100, 32'd0, 0, 0, 1, 1'b1, 32'h0040_0024, 32'h0040_0100);
    run_instr(32'h0200_0008, v_jr, 32'hFFFF_FFFC, 32'd0, 0, 0, 1, 1'b1, 32'h0040_0104, 32'hFFFF_FFFC);
    run_instr(32'hFC00_0000, 32'd0, 32'd0, 32'd0, 0, 0, 1, 1'b1, 32'h0000_0000, 32'h0000_0000);

    reset_mid_fetch();
    run_instr(32'h2008_0005, v_addi, 32'd0, 32'd0, 2, 0, 1, 1'b1, 32'h0040_0004, 32'h0040_0004);

    for (int n = 0; n < 200; n++) begin
      rs = $urandom;
      rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
      case ($urandom_range(0, 9))
        0:       vec = 32'd0;
        1:       vec = $urandom;
        2:       vec = v_j;
        3:       vec = v_jal;
        4:       vec = v_jr;
        5:       vec = v_beq;
        6:       vec = v_bne;
        7:       vec = v_beq | v_bne | (($urandom_range(0, 1) == 0) ? v_jr : 32'd0);
        default: vec = 32'd1 << $urandom_range(0, 30);
      endcase
      if ($urandom_range(0, 19) == 0) reset_mid_fetch();
      run_instr($urandom, vec, rs, rt, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), 1'b0, 32'd0, 32'd0);
    end

    step();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
